itrx_aib_phy_init_seq: RTL
==========================

ITRX_AIB_PHY_INIT_SEQ -- requirements
Module: itrx_aib_phy_init_seq

Interface
REQ-001 Parameter NWR, 8: number of APB configuration writes per bring-up (1..16).
REQ-002 Parameter DET_CYC, 16: consecutive device_detect-high cycles required (debounce).
REQ-003 Parameter TMO_CYC, 65535: per-phase timeout in pclk cycles (16-bit max).
REQ-004 pclk  in  1  sole clock; all logic rising-edge.
REQ-005 presetn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  single-cycle bring-up request; honoured only in IDLE, DONE or ERR.
REQ-007 abort  in  1  level; requests return to IDLE.
REQ-008 device_detect  in  1  far-side detect, already synchronized to pclk.
REQ-009 conf_done  in  1  AIB CONF_DONE, already synchronized to pclk.
REQ-010 paddr  out  12  APB master address.
REQ-011 pwrite  out  1  APB direction; 1 whenever psel=1.
REQ-012 psel  out  1  APB select.
REQ-013 penable  out  1  APB enable.
REQ-014 pwdata  out  32  APB write data.
REQ-015 pready  in  1  APB slave ready.
REQ-016 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-017 init_done  out  1  high while in DONE.
REQ-018 init_err  out  1  high while in ERR.
REQ-019 err_code  out  2  0=none, 1=detect timeout, 2=conf_done timeout; held until the next start.

Function
REQ-020 States SHALL be IDLE, WAIT_DET, SETUP, ACCESS, WAIT_CONF, DONE, ERR.
REQ-021 IDLE/DONE/ERR + start -> WAIT_DET next cycle; debounce counter, timeout counter, write index and err_code clear to 0.
REQ-022 WAIT_DET: debounce count increments while device_detect=1 and clears to 0 when it is 0; count reaching DET_CYC -> SETUP.
REQ-023 In WAIT_DET and WAIT_CONF, the timeout counter increments every cycle; on reaching TMO_CYC, go to ERR with err_code 1 or 2 respectively. Timeout counter clears on every state change.
REQ-024 SETUP: psel=1, penable=0, paddr/pwdata = ROM entry[index]; next cycle -> ACCESS.
REQ-025 ACCESS: psel=1, penable=1; paddr/pwdata held stable. Hold while pready=0 (no timeout). On pready=1: index+1; if index was NWR-1 -> WAIT_CONF, else -> SETUP next cycle (back-to-back, no idle gap).
REQ-026 WAIT_CONF: conf_done=1 -> DONE. conf_done=1 on the same cycle as the timeout -> DONE (success wins).
REQ-027 DONE: remain until start or abort; a drop of device_detect SHALL NOT leave DONE.
REQ-028 abort in WAIT_DET/WAIT_CONF/DONE/ERR -> IDLE next cycle. abort in SETUP/ACCESS: complete the current transfer (through pready=1), then -> IDLE; no further SETUP is issued.
REQ-029 abort has priority over start when both are asserted in the same cycle.
REQ-030 start while busy SHALL be ignored.
REQ-031 Outside SETUP/ACCESS: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
REQ-032 Counters SHALL saturate and never wrap; index width = clog2(NWR), minimum 1 bit.

Reset
REQ-033 presetn=0 at a rising edge -> IDLE, all counters 0, err_code=0, all outputs 0. This applies mid-transfer as well (APB abandoned; the slave is reset by the same presetn).
REQ-034 start, abort and device_detect have no effect while presetn=0.

Structure
REQ-035 Package itrx_aib_phy_init_pkg SHALL hold the state enum, the err_code enum, the ROM entry struct {addr[11:0], data[31:0]}, and the default register-table constants.
REQ-036 Sub-module itrx_aib_phy_init_rom: combinational index -> entry lookup; entries beyond NWR-1 return 0.
REQ-037 One FSM plus datapath counters in a single always_ff; no latches; no other clocks.

Verification
REQ-038 DET_CYC=4, NWR=2: device_detect high, pready=1 -> 2 writes SETUP/ACCESS back-to-back, then conf_done=1 -> init_done=1 and busy=0.
REQ-039 device_detect toggles 1,1,1,0,1,1,1,1 -> SETUP entered only after the final 4-cycle run.
REQ-040 pready low for 5 cycles in ACCESS -> paddr, pwdata, psel=1 and penable=1 held stable for 6 cycles.
REQ-041 TMO_CYC=10, device_detect=0 -> ERR after 10 cycles, err_code=1, init_err=1; start -> err_code cleared.
REQ-042 abort during ACCESS with pready=0 for 3 cycles -> transfer completes, then IDLE; psel=0 thereafter.
REQ-043 presetn=0 during ACCESS -> next edge all outputs 0 in IDLE; start after release -> full sequence rerun from index 0.

Source files
------------

// File: rtl/itrx_aib_phy_init_seq_pkg.sv
// Shared types and the default AIB PHY configuration table for the
// bring-up sequencer.
package itrx_aib_phy_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DET,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_CONF,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_DET_TMO  = 2'd1,
        ERR_CONF_TMO = 2'd2
    } err_code_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } rom_entry_t;

    localparam int ROM_DEPTH = 16;

    localparam logic [11:0] DEF_ADDR [ROM_DEPTH] = '{
        12'h100, 12'h104, 12'h110, 12'h114, 12'h120, 12'h124, 12'h130, 12'h134,
        12'h140, 12'h144, 12'h150, 12'h154, 12'h160, 12'h164, 12'h170, 12'h174
    };

    localparam logic [31:0] DEF_DATA [ROM_DEPTH] = '{
        32'h0000_0001, 32'h0000_00A5, 32'h1234_5678, 32'hDEAD_BEEF,
        32'h0F0F_0F0F, 32'h8000_0000, 32'h0000_FFFF, 32'hCAFE_F00D,
        32'h0101_0101, 32'h7FFF_FFFF, 32'h0000_0003, 32'hA5A5_5A5A,
        32'h0000_1000, 32'h3C3C_3C3C, 32'hFFFF_0000, 32'h0000_0080
    };

    // Write-index width: enough bits for NWR entries, never narrower than 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_init_seq_if.sv
// APB bus between the bring-up sequencer (master) and the PHY register
// block (slave).
interface itrx_aib_phy_init_seq_if;
    logic [11:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pready;

    modport master (output paddr, pwrite, psel, penable, pwdata, input pready);
    modport slave  (input paddr, pwrite, psel, penable, pwdata, output pready);
endinterface

// File: rtl/itrx_aib_phy_init_seq_rom.sv
// Combinational lookup of the configuration write table; slots at or past
// the configured write count read as zero.
module itrx_aib_phy_init_rom
    import itrx_aib_phy_init_pkg::*;
#(
    parameter int NWR   = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    output rom_entry_t       entry
);

    logic [3:0] slot;

    // Index into the 16-deep default table, masked beyond NWR-1
    always_comb begin
        slot  = 4'(idx);
        entry = '0;
        if (int'(slot) < NWR) begin
            entry.addr = DEF_ADDR[slot];
            entry.data = DEF_DATA[slot];
        end
    end

endmodule

// File: rtl/itrx_aib_phy_init_seq.sv
// AIB PHY bring-up sequencer: debounces far-side detect, pushes NWR APB
// configuration writes, then waits for CONF_DONE with per-phase timeouts.
module itrx_aib_phy_init_seq
    import itrx_aib_phy_init_pkg::*;
#(
    parameter int NWR     = 8,
    parameter int DET_CYC = 16,
    parameter int TMO_CYC = 65535
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           device_detect,
    input  logic                           conf_done,
    itrx_aib_phy_init_seq_if.master        apb,
    output logic                           busy,
    output logic                           init_done,
    output logic                           init_err,
    output logic [1:0]                     err_code
);

    localparam int IDX_W = idx_width(NWR);
    localparam int DET_W = $clog2(DET_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWR - 1);
    localparam logic [DET_W-1:0] DET_LAST = DET_W'(DET_CYC - 1);
    localparam logic [DET_W-1:0] DET_MAX  = DET_W'(DET_CYC);
    localparam logic [15:0]      TMO_LAST = 16'(TMO_CYC - 1);

    state_t           state, nxt;
    err_code_t        err_q, err_nxt;
    logic [DET_W-1:0] det_cnt;
    logic [15:0]      tmo_cnt;
    logic [IDX_W-1:0] idx;
    logic             abort_pend;
    logic             start_go;
    logic             det_hit;
    logic             tmo_hit;
    logic             xfer;
    rom_entry_t       entry;

    itrx_aib_phy_init_rom #(.NWR(NWR), .IDX_W(IDX_W)) u_rom (
        .idx   (idx),
        .entry (entry)
    );

    assign det_hit = device_detect && (det_cnt == DET_LAST);
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign xfer    = (state == ST_SETUP) || (state == ST_ACCESS);

    assign apb.psel    = xfer;
    assign apb.penable = (state == ST_ACCESS);
    assign apb.pwrite  = xfer;
    assign apb.paddr   = xfer ? entry.addr : '0;
    assign apb.pwdata  = xfer ? entry.data : '0;

    assign busy      = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign init_done = (state == ST_DONE);
    assign init_err  = (state == ST_ERR);
    assign err_code  = err_q;

    // Next-state decode; abort outranks start, and success outranks timeout
    always_comb begin
        nxt      = state;
        err_nxt  = err_q;
        start_go = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (abort) begin
                    nxt = ST_IDLE;
                end else if (start) begin
                    nxt      = ST_WAIT_DET;
                    start_go = 1'b1;
                end
            end
            ST_WAIT_DET: begin
                if (abort) begin
                    nxt = ST_IDLE;
                end else if (det_hit) begin
                    nxt = ST_SETUP;
                end else if (tmo_hit) begin
                    nxt     = ST_ERR;
                    err_nxt = ERR_DET_TMO;
                end
            end
            ST_SETUP: nxt = ST_ACCESS;
            ST_ACCESS: begin
                // A pending abort only takes effect once the slave completes
                if (apb.pready) begin
                    if (abort || abort_pend) nxt = ST_IDLE;
                    else if (idx == IDX_LAST) nxt = ST_WAIT_CONF;
                    else nxt = ST_SETUP;
                end
            end
            ST_WAIT_CONF: begin
                if (abort) begin
                    nxt = ST_IDLE;
                end else if (conf_done) begin
                    nxt = ST_DONE;
                end else if (tmo_hit) begin
                    nxt     = ST_ERR;
                    err_nxt = ERR_CONF_TMO;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // State register plus saturating debounce/timeout counters and write index
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state      <= ST_IDLE;
            err_q      <= ERR_NONE;
            det_cnt    <= '0;
            tmo_cnt    <= '0;
            idx        <= '0;
            abort_pend <= 1'b0;
        end else begin
            state <= nxt;
            if (start_go) begin
                err_q      <= ERR_NONE;
                det_cnt    <= '0;
                tmo_cnt    <= '0;
                idx        <= '0;
                abort_pend <= 1'b0;
            end else begin
                err_q <= err_nxt;
                if (state == ST_WAIT_DET) begin
                    if (!device_detect) det_cnt <= '0;
                    else if (det_cnt != DET_MAX) det_cnt <= det_cnt + 1'b1;
                end
                if (nxt != state) begin
                    tmo_cnt <= '0;
                end else if (((state == ST_WAIT_DET) || (state == ST_WAIT_CONF)) &&
                             (tmo_cnt != 16'hFFFF)) begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                if ((state == ST_ACCESS) && apb.pready && (idx != IDX_LAST)) begin
                    idx <= idx + 1'b1;
                end
                if (nxt == ST_IDLE) abort_pend <= 1'b0;
                else if (abort && xfer) abort_pend <= 1'b1;
            end
        end
    end

endmodule
